apb_master_arb: RTL and testbench

Round-robin arbiter and APB master sequencer that shares one APB slave port among `NREQ` local requesters. It accepts one request at a time and drives the SETUP and ACCESS phases, including wait states. It returns read data and error status to the requester that issued the request. It sits between the TSC control clients and the `apb_interface` bus, and drives the master side of that bus.

---
 rtl/apb_arb_pkg.sv | 27 ++
 rtl/apb_master_arb_rr_arbiter.sv | 66 ++++++
 rtl/apb_master_arb.sv | 168 ++++++++++++++++
 tb/tb_apb_master_arb.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg
// Shared types and helpers for the APB master arbiter.
//   apb_arb_state_e  : sequencer state (IDLE, SETUP, ACCESS)
//   APB_ARB_MAX_REQ  : largest supported requester count
//   APB_ARB_IDX_W    : width of a requester index (sized for APB_ARB_MAX_REQ)
//   idx_to_onehot()  : index -> one-hot mask of APB_ARB_MAX_REQ bits
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_e;

    localparam int APB_ARB_MAX_REQ = 8;
    localparam int APB_ARB_IDX_W   = $clog2(APB_ARB_MAX_REQ);

    function automatic logic [APB_ARB_MAX_REQ-1:0] idx_to_onehot(
        input logic [APB_ARB_IDX_W-1:0] idx
    );
        logic [APB_ARB_MAX_REQ-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/apb_master_arb_rr_arbiter.sv
// rr_arbiter
// Round-robin one-hot arbiter with a registered priority pointer.
// The pointer names the highest-priority requester; it moves to the
// requester just after the winner whenever grant_en is high and at least
// one request is present. Reset puts requester 0 on top.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req [NREQ]      : request vector
//   grant_en        : this cycle is an arbitration cycle (commits the grant)
//   grant [NREQ]    : combinational one-hot winner (zero when no request)
//   grant_idx       : index of the winner
//   any             : at least one request present
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic                     grant_en,
    output logic [NREQ-1:0]          grant,
    output logic [APB_ARB_IDX_W-1:0] grant_idx,
    output logic                     any
);

    logic [APB_ARB_IDX_W-1:0] r_ptr;
    logic [NREQ-1:0]          w_mask;
    logic [NREQ-1:0]          w_hi;
    logic [NREQ-1:0]          w_pick;

    // Requesters at or above the pointer are searched first; if none of
    // them is asking, the search wraps to the full vector.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (APB_ARB_IDX_W'(i) >= r_ptr) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    assign w_hi   = req & w_mask;
    assign w_pick = (|w_hi) ? w_hi : req;
    // Isolate the lowest set bit of the chosen vector.
    assign grant  = w_pick & (~w_pick + NREQ'(1));
    assign any    = |req;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = APB_ARB_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (grant_en && any) begin
            r_ptr <= (grant_idx == APB_ARB_IDX_W'(NREQ - 1)) ? '0 : grant_idx + APB_ARB_IDX_W'(1);
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb
// Shares one APB slave port among NREQ local requesters. One request is
// accepted at a time (round-robin), driven through SETUP and ACCESS with
// wait states, and the result is returned to the issuing requester as a
// one-cycle registered pulse.
// Optional feature macro: APB_ARB_TIMEOUT_EN -- when defined, an ACCESS
// phase that sees TO_CYC cycles of pready=0 is force-completed with
// rsp_err=1 and rsp_rdata=0.
// Ports:
//   pclk, preset                 : clock, synchronous active-high reset
//   req_valid/write [NREQ]       : request strobe and direction per requester
//   req_addr [NREQ*AW]           : flattened addresses, slice [i*AW +: AW]
//   req_wdata [NREQ*DW]          : flattened write data, slice [i*DW +: DW]
//   req_ready [NREQ]             : combinational one-hot accept
//   rsp_valid [NREQ]             : one-hot response pulse
//   rsp_rdata, rsp_err           : response payload, valid with rsp_valid
//   psel/penable/pwrite/paddr/pwdata : APB master outputs (registered)
//   prdata/pready/pslverr        : APB slave inputs
//   dbg_state                    : current sequencer state (apb_arb_state_e)
// Handshake: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high; fields must be held while valid waits.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int AW     = 6,
    parameter int DW     = 32,
    parameter int TO_CYC = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AW-1:0]     paddr,
    output logic [DW-1:0]     pwdata,
    input  logic [DW-1:0]     prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic [1:0]        dbg_state
);

    apb_arb_state_e           r_state;
    logic [APB_ARB_IDX_W-1:0] r_gidx;

    logic [NREQ-1:0]          w_grant;
    logic [APB_ARB_IDX_W-1:0] w_gidx;
    logic                     w_any;
    logic                     w_to;
    logic                     w_done;
    logic                     w_arb;
    logic                     w_grant_en;
    logic                     w_write;
    logic [AW-1:0]            w_addr;
    logic [DW-1:0]            w_wdata;

    // The completing ACCESS cycle doubles as an arbitration cycle so that
    // back-to-back transfers cost two cycles each.
    assign w_done     = (r_state == ACCESS) && (pready || w_to);
    assign w_arb      = (r_state == IDLE) || w_done;
    assign w_grant_en = w_arb && !preset;
    assign req_ready  = w_grant_en ? w_grant : '0;
    assign dbg_state  = r_state;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk       (pclk),
        .rst       (preset),
        .req       (req_valid),
        .grant_en  (w_grant_en),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .any       (w_any)
    );

    // Fields of the winning requester.
    always_comb begin
        w_write = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_write = req_write[i];
                w_addr  = req_addr[i*AW +: AW];
                w_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Fires only while the slave is still stalling; a real pready wins.
    assign w_to = (r_state == ACCESS) && !pready && (r_to_cnt == TO_W'(TO_CYC));

    always_ff @(posedge pclk) begin
        if (preset || (r_state == SETUP)) begin
            r_to_cnt <= '0;
        end else if ((r_state == ACCESS) && !pready && !w_to) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= IDLE;
            r_gidx    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (w_done) begin
                rsp_valid <= NREQ'(idx_to_onehot(r_gidx));
                rsp_err   <= w_to | pslverr;
                rsp_rdata <= (pwrite || w_to) ? '0 : prdata;
            end

            case (r_state)
                IDLE, ACCESS: begin
                    if (w_arb && w_any) begin
                        // New SETUP: psel stays (or goes) high, penable low.
                        r_state <= SETUP;
                        r_gidx  <= w_gidx;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= w_write;
                        paddr   <= w_addr;
                        pwdata  <= w_wdata;
                    end else if (w_done) begin
                        // Address/data hold their last values in IDLE.
                        r_state <= IDLE;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                    penable <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
module tb_apb_master_arb;
    localparam int NREQ   = 4;
    localparam int AW     = 6;
    localparam int DW     = 32;
    localparam int TO_CYC = 16;
    localparam int EW     = NREQ + 1 + DW;

    logic               pclk, preset;
    logic [NREQ-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]      rsp_rdata, pwdata, prdata;
    logic               rsp_err, psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0]      paddr;
    logic [1:0]         dbg_state;

    apb_master_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TO_CYC(TO_CYC)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int            idx;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t            txn_q[$];   // granted, not yet completed
    logic [EW-1:0]   exp_q[$];   // {one-hot index, err, rdata} due next cycle
    int              m_last = NREQ - 1;
    int              m_age  = 0;  // cycles since the outstanding grant
    int              cyc = 0;
    int              grant_log[$];
    int              grant_cyc = 0, rsp_cyc = 0, acc_run = 0, access_len = 0;
    int              psel_low_cnt = 0, rsp_cnt = 0;
    logic [NREQ-1:0] acc_seen = '0;
    logic [NREQ-1:0] last_rsp_valid = '0;
    logic [DW-1:0]   last_rsp_rdata = '0;
    logic            last_rsp_err = 1'b0;

    logic [EW-1:0]   m_e;
    logic [NREQ-1:0] m_oh;
    logic            m_out, m_done, m_to;
    int              m_g;
    txn_t            m_t;

    // First requester after the last-granted one, wrapping around.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge pclk) begin
        cyc++;
        acc_seen = req_valid & req_ready;
        if (!psel) psel_low_cnt++;
        if (preset) begin
            check_eq("ready_in_reset", 64'(req_ready), 64'd0);
            txn_q.delete();
            exp_q.delete();
            m_last = NREQ - 1;
            m_age  = 0;
        end else begin
            if (exp_q.size() != 0) begin
                m_e = exp_q.pop_front();
                check_eq("rsp_valid", 64'(rsp_valid), 64'(m_e[EW-1 -: NREQ]));
                check_eq("rsp_err", 64'(rsp_err), 64'(m_e[DW]));
                check_eq("rsp_rdata", 64'(rsp_rdata), 64'(m_e[DW-1:0]));
            end else begin
                check_eq("rsp_quiet", 64'(rsp_valid), 64'd0);
            end
            if (rsp_valid != '0) begin
                rsp_cnt++;
                rsp_cyc        = cyc;
                last_rsp_valid = rsp_valid;
                last_rsp_rdata = rsp_rdata;
                last_rsp_err   = rsp_err;
            end

            m_out = (txn_q.size() != 0);
            check_eq("psel", 64'(psel), 64'(m_out));
            check_eq("penable", 64'(penable), 64'(m_out && m_age >= 2));
            if (m_out) begin
                check_eq("paddr", 64'(paddr), 64'(txn_q[0].addr));
                check_eq("pwrite", 64'(pwrite), 64'(txn_q[0].wr));
                check_eq("pwdata", 64'(pwdata), 64'(txn_q[0].wdata));
                if (psel && penable) acc_run++;
            end

            m_to = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            m_to = m_out && (m_age == TO_CYC + 2) && !pready;
`endif
            m_done = m_out && (m_age >= 2) && (pready || m_to);
            if (m_done) begin
                m_t  = txn_q.pop_front();
                m_oh = '0;
                m_oh[m_t.idx] = 1'b1;
                exp_q.push_back({m_oh, (m_to ? 1'b1 : pslverr),
                                 ((m_t.wr || m_to) ? {DW{1'b0}} : prdata)});
                access_len = acc_run;
            end

            m_g = (txn_q.size() != 0) ? -1 : rr_pick(req_valid, m_last);
            if (m_g >= 0) begin
                check_eq("req_ready", 64'(req_ready), 64'd1 << m_g);
                m_t.idx   = m_g;
                m_t.wr    = req_write[m_g];
                m_t.addr  = req_addr[m_g*AW +: AW];
                m_t.wdata = req_wdata[m_g*DW +: DW];
                txn_q.push_back(m_t);
                m_last = m_g;
                m_age  = 0;
                grant_log.push_back(m_g);
                grant_cyc = cyc;
                acc_run   = 0;
            end else begin
                check_eq("req_ready_idle", 64'(req_ready), 64'd0);
            end
            m_age++;
        end
    end

    // ---------------- APB slave model ----------------
    int            s_mode = 0;   // 0 random, 1 fixed, 2 stuck pready=0
    int            s_waits = 0;
    logic [DW-1:0] s_rdata = '0;
    logic          s_err = 1'b0;
    int            w_left = 0;

    always @(posedge pclk) begin
        #1;
        if (psel && !penable) begin
            w_left = (s_mode == 0) ? $urandom_range(0, 3) : s_waits;
            pready = 1'b0;
        end else if (psel && penable) begin
            if (s_mode == 2) pready = 1'b0;
            else if (w_left == 0) pready = 1'b1;
            else begin
                pready = 1'b0;
                w_left--;
            end
        end else begin
            pready = 1'b0;
        end
        prdata  = (s_mode == 1) ? s_rdata : $urandom;
        pslverr = (s_mode == 1) ? s_err : ($urandom_range(0, 3) == 0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_fields(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic issue(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_fields(i, wr, a, d);
        req_valid[i] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (acc_seen[i]) begin
                req_valid[i] = 1'b0;
                return;
            end
        end
        req_valid[i] = 1'b0;
        check_eq("issue_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (txn_q.size() == 0 && exp_q.size() == 0) return;
        end
        check_eq("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (req_valid == '0) return;
            tick();
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && acc_seen[i]) req_valid[i] = 1'b0;
        end
        check_eq("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_random(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && acc_seen[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_fields(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
                    else
                        req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_fields(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
                    req_valid[i] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- test sequence ----------------
    int base, p0, rc;
    bit got0;

    initial begin
        preset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        repeat (3) tick();
        @(negedge pclk);
        check_eq("rst_psel", 64'(psel), 64'd0);
        check_eq("rst_penable", 64'(penable), 64'd0);
        check_eq("rst_pwrite", 64'(pwrite), 64'd0);
        check_eq("rst_paddr", 64'(paddr), 64'd0);
        check_eq("rst_pwdata", 64'(pwdata), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
        tick();
        preset = 1'b0;
        repeat (2) tick();

        // Single zero-wait read by requester 1.
        s_mode = 1; s_waits = 0; s_rdata = 32'hDEADBEEF; s_err = 1'b0;
        issue(1, 1'b0, 6'h04, '0);
        wait_done(20);
        check_eq("rd_latency", 64'(rsp_cyc - grant_cyc), 64'd3);
        check_eq("rd_rsp_valid", 64'(last_rsp_valid), 64'b0010);
        check_eq("rd_rsp_rdata", 64'(last_rsp_rdata), 64'hDEADBEEF);
        check_eq("rd_rsp_err", 64'(last_rsp_err), 64'd0);

        // Write with 3 wait states by requester 0.
        s_waits = 3;
        issue(0, 1'b1, 6'h08, 32'h12345678);
        wait_done(30);
        check_eq("wr_latency", 64'(rsp_cyc - grant_cyc), 64'd6);
        check_eq("wr_access_len", 64'(access_len), 64'd4);
        check_eq("wr_rsp_valid", 64'(last_rsp_valid), 64'b0001);
        check_eq("wr_rsp_rdata", 64'(last_rsp_rdata), 64'd0);

        // All four requesting from reset, zero-wait slave.
        s_waits = 0;
        preset = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            set_fields(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
            req_valid[i] = 1'b1;
        end
        repeat (2) tick();
        base = grant_log.size();
        got0 = 1'b0;
        p0   = 0;
        preset = 1'b0;
        for (int k = 0; k < 40 && grant_log.size() < base + 5; k++) begin
            tick();
            if (!got0 && grant_log.size() >= base + 1) begin
                got0 = 1'b1;
                p0   = psel_low_cnt;
            end
        end
        check_eq("rr_grants", 64'(grant_log.size() - base), 64'd5);
        if (grant_log.size() >= base + 5) begin
            check_eq("rr_order0", 64'(grant_log[base]),     64'd0);
            check_eq("rr_order1", 64'(grant_log[base + 1]), 64'd1);
            check_eq("rr_order2", 64'(grant_log[base + 2]), 64'd2);
            check_eq("rr_order3", 64'(grant_log[base + 3]), 64'd3);
            check_eq("rr_order4", 64'(grant_log[base + 4]), 64'd0);
            check_eq("rr_psel_gaps", 64'(psel_low_cnt - p0), 64'd0);
        end
        drain();
        wait_done(40);

        // Slave error, then a normal read.
        s_err = 1'b1; s_rdata = $urandom;
        issue(2, 1'b0, 6'h20, '0);
        wait_done(20);
        check_eq("err_rsp_err", 64'(last_rsp_err), 64'd1);
        check_eq("err_rsp_valid", 64'(last_rsp_valid), 64'b0100);
        s_err = 1'b0; s_rdata = 32'hA5A5_0F0F;
        issue(3, 1'b0, 6'h24, '0);
        wait_done(20);
        check_eq("after_err_err", 64'(last_rsp_err), 64'd0);
        check_eq("after_err_rdata", 64'(last_rsp_rdata), 64'hA5A5_0F0F);

        // Reset during ACCESS wait states.
        s_mode = 2;
        issue(2, 1'b0, 6'h10, '0);
        repeat (3) tick();
        set_fields(0, 1'b1, 6'h11, 32'h0000_1111);
        set_fields(3, 1'b1, 6'h33, 32'h0000_3333);
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        tick();
        rc = rsp_cnt;
        preset = 1'b1;
        tick();
        preset = 1'b0;
        s_mode = 1; s_waits = 0;
        @(negedge pclk);
        check_eq("rst_mid_psel", 64'(psel), 64'd0);
        tick();
        check_eq("rst_mid_first_grant", 64'(grant_log[grant_log.size() - 1]), 64'd0);
        req_valid[0] = 1'b0;
        drain();
        wait_done(30);
        check_eq("rst_mid_rsp_count", 64'(rsp_cnt - rc), 64'd2);

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never ready: forced completion with error.
        s_mode = 2;
        issue(1, 1'b0, 6'h3C, '0);
        wait_done(60);
        check_eq("to_latency", 64'(rsp_cyc - grant_cyc), 64'(TO_CYC + 3));
        check_eq("to_rsp_err", 64'(last_rsp_err), 64'd1);
        check_eq("to_rsp_rdata", 64'(last_rsp_rdata), 64'd0);
`endif

        // Randomized traffic against the model.
        s_mode = 0;
        run_random(2000);
        drain();
        wait_done(60);
        check_eq("final_idle_psel", 64'(psel), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
